uart_tx_arbiter: RTL

//  Shares one uart_tx transmitter between NUM_REQ byte-stream requesters. Arbitration is

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that shares one uart_tx between NUM_REQ byte streams.
// A grant is held from a requester's first byte until its last byte leaves uart_tx.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ACK_TIMEOUT  = 4,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                 i_uart_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_tx_write,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  output logic                 o_ack_timeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ACK_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int GAP_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
  localparam logic [ACK_W-1:0] ACK_LAST  = (ACK_TIMEOUT > 0) ? ACK_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LAST  = (LOCK_TIMEOUT > 0) ? GAP_W'(LOCK_TIMEOUT - 1) : '0;

  // state     | meaning
  // IDLE      | no owner; pick the next requester round-robin
  // LOAD      | owner holds uart_tx, waiting for its next byte
  // SEND      | byte latched, pulse write once uart_tx is free
  // WAIT_ACK  | write issued, waiting for busy to rise
  // WAIT_DONE | uart_tx shifting the byte out
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic               last_q;
  logic [ACK_W-1:0]   ack_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [2*NUM_REQ-1:0] valid_rot;
  logic [PTR_W-1:0]     win_off;
  logic [PTR_W:0]       win_sum;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic [PTR_W-1:0]     next_ptr;
  logic                 take;
  logic                 byte_done;
  logic                 lock_expire;
  logic                 release_grant;

  // Rotate valids so offset 0 is the RR pointer, then take the lowest set offset.
  always_comb begin
    valid_rot = {i_req_valid, i_req_valid} >> rr_ptr;
    win_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) win_off = PTR_W'(k);
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= NUM_REQ_W) win_sum = win_sum - NUM_REQ_W;
    win_idx    = win_sum[PTR_W-1:0];
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    next_ptr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant[k]) begin
        sel_data = i_req_data[8*k +: 8];
        sel_last = i_req_last[k];
        next_ptr = PTR_W'((k + 1) % NUM_REQ);
      end
    end
  end

  assign o_req_ready = (state == S_LOAD) ? (o_grant & i_req_valid) : '0;
  assign o_tx_write  = (state == S_SEND) && !i_tx_busy;
  assign take        = |o_req_ready;

  assign byte_done = ((state == S_WAIT_ACK) && !i_tx_busy && (ack_cnt == ACK_LAST)) ||
                     ((state == S_WAIT_DONE) && !i_tx_busy);
  assign lock_expire = (LOCK_TIMEOUT != 0) && (state == S_LOAD) && !take &&
                       (gap_cnt == GAP_LAST);
  assign release_grant = (byte_done && last_q) || lock_expire;

  always_ff @(posedge i_uart_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_grant       <= '0;
      o_tx_data     <= '0;
      o_ack_timeout <= 1'b0;
      rr_ptr        <= '0;
      last_q        <= 1'b0;
      ack_cnt       <= '0;
      gap_cnt       <= '0;
    end else begin
      o_ack_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_req_valid) begin
            o_grant <= win_onehot;
            gap_cnt <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (take) begin
            o_tx_data <= sel_data;
            last_q    <= sel_last;
            gap_cnt   <= '0;
            state     <= S_SEND;
          end else if (LOCK_TIMEOUT != 0) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (!i_tx_busy) begin
            ack_cnt <= '0;
            state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            o_ack_timeout <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
        end
        default: state <= S_IDLE;
      endcase

      // Completion and release override the per-state updates above.
      if (release_grant) begin
        o_grant <= '0;
        rr_ptr  <= next_ptr;
        state   <= S_IDLE;
      end else if (byte_done) begin
        gap_cnt <= '0;
        state   <= S_LOAD;
      end
    end
  end

endmodule
